// File: rtl/issue_prf_wb_arbiter.sv
// Writeback arbiter: three result sources, each buffered in a 2-deep FIFO,
// round-robin granted onto the single PRF write port with a wakeup copy.
// Ports:
//   clk, reset (sync, active-high), flush
//   srcN_valid/srcN_ready/srcN_dst/srcN_data  source N result handshake (N=0..2)
//   prf_addr/prf_we/prf_din                   registered PRF write port
//   wakeup_valid/wakeup_dst                   copies of prf_we/prf_addr
module issue_prf_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [5:0]  src0_dst,
  input  logic [63:0] src0_data,
  input  logic        src1_valid,
  output logic        src1_ready,
  input  logic [5:0]  src1_dst,
  input  logic [63:0] src1_data,
  input  logic        src2_valid,
  output logic        src2_ready,
  input  logic [5:0]  src2_dst,
  input  logic [63:0] src2_data,
  output logic [5:0]  prf_addr,
  output logic        prf_we,
  output logic [63:0] prf_din,
  output logic        wakeup_valid,
  output logic [5:0]  wakeup_dst
);

  typedef struct packed {
    logic [5:0]  dst;
    logic [63:0] data;
  } wb_t;

  wb_t [1:0]       mem_q [3];
  wb_t             in_s  [3];
  wb_t             head  [3];
  logic [2:0]      vld;
  logic [2:0]      rdy;
  logic [2:0]      push;
  logic [2:0]      pop;
  logic [2:0]      nempty;

  logic [2:0][1:0] cnt_q, cnt_d;
  logic [2:0]      wptr_q, wptr_d;
  logic [2:0]      rptr_q, rptr_d;
  logic [1:0]      rr_q, rr_d;
  logic            we_q, we_d;
  logic [5:0]      addr_q, addr_d;
  logic [63:0]     din_q, din_d;

  logic            win_vld;
  logic [1:0]      win;
  logic [1:0]      idx;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign in_s[0] = {src0_dst, src0_data};
  assign in_s[1] = {src1_dst, src1_data};
  assign in_s[2] = {src2_dst, src2_data};
  assign vld     = {src2_valid, src1_valid, src0_valid};

  assign src0_ready = rdy[0];
  assign src1_ready = rdy[1];
  assign src2_ready = rdy[2];

  // Ready looks only at the registered count, so a pop in the same
  // cycle never re-opens a full FIFO.
  always_comb begin
    rdy    = '0;
    nempty = '0;
    for (int i = 0; i < 3; i++) begin
      rdy[i]    = !reset && (cnt_q[i] < 2'd2);
      nempty[i] = (cnt_q[i] != 2'd0);
      head[i]   = mem_q[i][rptr_q[i]];
    end
  end

  // First non-empty FIFO at or after rr_q, wrapping mod 3.
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    idx     = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && nempty[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
      idx = inc3(idx);
    end
  end

  always_comb begin
    push   = '0;
    pop    = '0;
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    rr_d   = rr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    if (flush) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        push[i] = vld[i] && rdy[i];
        pop[i]  = win_vld && (win == 2'(i));
        if (push[i]) wptr_d[i] = ~wptr_q[i];
        if (pop[i])  rptr_d[i] = ~rptr_q[i];
        cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
      if (win_vld) begin
        we_d   = 1'b1;
        addr_d = head[win].dst;
        din_d  = head[win].data;
        rr_d   = inc3(win);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      rr_q   <= 2'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      rr_q   <= rr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // Storage needs no reset; push is already gated by reset and flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_s[i];
    end
  end

  assign prf_we       = we_q;
  assign prf_addr     = addr_q;
  assign prf_din      = din_q;
  assign wakeup_valid = we_q;
  assign wakeup_dst   = addr_q;

endmodule

// File: tb/tb_issue_prf_wb_arbiter.sv
// Scoreboard bench for issue_prf_wb_arbiter.
// Per-source expected queues filled on handshake, drained on PRF writes.
module tb_issue_prf_wb_arbiter;

  typedef struct packed {
    logic [5:0]  dst;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  v = '0;
  logic [2:0]  rd;
  logic [5:0]  dst [3];
  logic [63:0] dat [3];
  logic [5:0]  prf_addr;
  logic        prf_we;
  logic [63:0] prf_din;
  logic        wakeup_valid;
  logic [5:0]  wakeup_dst;

  beat_t plan [3][$];
  beat_t expq [3][$];
  int    gnt_log [$];
  int    wcyc [$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_bad = 0;
  int    n_wr = 0;
  int    disc = 0;
  logic  stall0 = 1'b0;

  always #5 clk = ~clk;

  issue_prf_wb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src0_valid(v[0]), .src0_ready(rd[0]),
    .src0_dst(dst[0]), .src0_data(dat[0]),
    .src1_valid(v[1]), .src1_ready(rd[1]),
    .src1_dst(dst[1]), .src1_data(dat[1]),
    .src2_valid(v[2]), .src2_ready(rd[2]),
    .src2_dst(dst[2]), .src2_data(dat[2]),
    .prf_addr(prf_addr), .prf_we(prf_we), .prf_din(prf_din),
    .wakeup_valid(wakeup_valid), .wakeup_dst(wakeup_dst)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < 3; s++) n += plan[s].size() + expq[s].size();
    return n;
  endfunction

  // Monitor: every PRF write must match the head of some source queue.
  always @(negedge clk) begin
    beat_t got;
    int    fs;
    logic  found;
    cyc++;
    if (prf_we === 1'b1) begin
      got   = {prf_addr, prf_din};
      found = 1'b0;
      fs    = 0;
      for (int s = 0; s < 3; s++) begin
        if (!found && expq[s].size() > 0 && expq[s][0] == got) begin
          found = 1'b1;
          fs    = s;
        end
      end
      chk("wr_match", {63'd0, found}, 64'd1);
      if (found) begin
        chk("wk_dst", {58'd0, wakeup_dst}, {58'd0, expq[fs][0].dst});
        chk("wk_v", {63'd0, wakeup_valid}, 64'd1);
        void'(expq[fs].pop_front());
        gnt_log.push_back(fs);
        wcyc.push_back(cyc);
        n_wr++;
      end
    end
    if (flush === 1'b1 && reset === 1'b0) begin
      for (int s = 0; s < 3; s++) begin
        disc += expq[s].size();
        expq[s].delete();
      end
    end
  end

  task automatic drive();
    for (int s = 0; s < 3; s++) begin
      v[s]   = plan[s].size() != 0;
      dst[s] = v[s] ? plan[s][0].dst  : 6'd0;
      dat[s] = v[s] ? plan[s][0].data : 64'd0;
    end
  endtask

  task automatic accept();
    for (int s = 0; s < 3; s++) begin
      if (v[s] && !rd[s]) begin
        if (s == 0) stall0 = 1'b1;
      end
      if (!reset && !flush && v[s] && rd[s])
        expq[s].push_back(plan[s].pop_front());
    end
    if (flush && !reset)
      for (int s = 0; s < 3; s++) plan[s].delete();
  endtask

  task automatic step();
    @(negedge clk);
    #1 accept();
    @(posedge clk);
    #1 drive();
  endtask

  task automatic drain();
    int k = 0;
    while (pending() > 0 && k < 300) begin
      step();
      k++;
    end
    chk("drain", 64'(pending()), 64'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    step();
    step();
    reset = 1'b0;
    gnt_log.delete();
    wcyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      dst[s] = '0;
      dat[s] = '0;
    end
    // Reset with all sources valid: nothing enters.
    for (int s = 0; s < 3; s++)
      plan[s].push_back({6'(40 + s), {32'(s + 48), 32'd7}});
    reset = 1'b1;
    drive();
    for (int r = 0; r < 2; r++) begin
      step();
      #1;
      chk("rst_rdy0", {63'd0, rd[0]}, 64'd0);
      chk("rst_rdy1", {63'd0, rd[1]}, 64'd0);
      chk("rst_rdy2", {63'd0, rd[2]}, 64'd0);
      chk("rst_we", {63'd0, prf_we}, 64'd0);
      chk("rst_addr", {58'd0, prf_addr}, 64'd0);
      chk("rst_din", prf_din, 64'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rdy0", {63'd0, rd[0]}, 64'd1);
    chk("post_rdy1", {63'd0, rd[1]}, 64'd1);
    chk("post_rdy2", {63'd0, rd[2]}, 64'd1);
    drain();

    // Single source latency.
    do_reset();
    plan[1].push_back({6'd5, 64'hDEADBEEF});
    drive();
    step();
    chk("ss_we_k", {63'd0, prf_we}, 64'd0);
    step();
    chk("ss_we", {63'd0, prf_we}, 64'd1);
    chk("ss_addr", {58'd0, prf_addr}, 64'd5);
    chk("ss_din", prf_din, 64'hDEADBEEF);
    chk("ss_wk", {58'd0, wakeup_dst}, 64'd5);
    step();
    chk("ss_we_k2", {63'd0, prf_we}, 64'd0);
    chk("ss_q", 64'(pending()), 64'd0);

    // Fairness: 4 beats per source back-to-back.
    do_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4; i++)
        plan[s].push_back({6'(s * 8 + i), {32'(s), 32'(i)}});
    drive();
    drain();
    chk("fair_n", 64'(gnt_log.size()), 64'd12);
    for (int i = 0; i < gnt_log.size() && i < 12; i++)
      chk("fair_ord", 64'(gnt_log[i]), 64'(i % 3));
    if (wcyc.size() == 12)
      chk("fair_span", 64'(wcyc[11] - wcyc[0]), 64'd11);

    // Backpressure: all three streaming, src0 must stall.
    stall0 = 1'b0;
    n_wr = 0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 10; i++)
        plan[s].push_back({6'(i + 20), {32'(s + 16), 32'(i)}});
    drive();
    drain();
    chk("bp_stall", {63'd0, stall0}, 64'd1);
    chk("bp_total", 64'(n_wr), 64'd30);

    // Flush with buffered beats and an incoming src1 beat.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      plan[0].push_back({6'(i + 1), {32'd32, 32'(i)}});
      plan[2].push_back({6'(i + 11), {32'd34, 32'(i)}});
    end
    drive();
    for (int i = 0; i < 5; i++) step();
    disc = 0;
    plan[1].push_back({6'd33, {32'd33, 32'd0}});
    flush = 1'b1;
    drive();
    chk("fl_inflight", {63'd0, prf_we}, 64'd1);
    step();
    flush = 1'b0;
    drive();
    #1;
    chk("fl_we", {63'd0, prf_we}, 64'd0);
    chk("fl_rdy0", {63'd0, rd[0]}, 64'd1);
    chk("fl_rdy1", {63'd0, rd[1]}, 64'd1);
    chk("fl_rdy2", {63'd0, rd[2]}, 64'd1);
    chk("fl_disc", {63'd0, disc != 0}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_quiet", {63'd0, prf_we}, 64'd0);
    end

    // Same destination from two sources.
    do_reset();
    plan[0].push_back({6'd9, 64'd1});
    plan[1].push_back({6'd9, 64'd2});
    drive();
    step();
    step();
    chk("col_a1", {58'd0, prf_addr}, 64'd9);
    chk("col_d1", prf_din, 64'd1);
    step();
    chk("col_we2", {63'd0, prf_we}, 64'd1);
    chk("col_a2", {58'd0, prf_addr}, 64'd9);
    chk("col_d2", prf_din, 64'd2);
    step();
    chk("col_we3", {63'd0, prf_we}, 64'd0);
    chk("col_n", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      chk("col_g0", 64'(gnt_log[0]), 64'd0);
      chk("col_g1", 64'(gnt_log[1]), 64'd1);
    end

    chk("end_empty", 64'(pending()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
